// File: rtl/alu_sequencer.sv
// alu_sequencer: RV32I/M register-op ALU; base ops finish in one cycle, MUL/DIV
// iterate one shift-add or restoring-subtract step per cycle on a double-width accumulator.
module alu_sequencer #(
    parameter int REG_DATA_WIDTH = 32,
    parameter bit MULDIV_EN      = 1'b1
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [6:0]                opcode,
    input  logic [2:0]                funct3,
    input  logic [6:0]                funct7,
    input  logic [REG_DATA_WIDTH-1:0] rs1_data,
    input  logic [REG_DATA_WIDTH-1:0] rs2_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [REG_DATA_WIDTH-1:0] result,
    output logic                      illegal,
    output logic [3:0]                alu_ctrl,
    output logic                      busy
);
    localparam int W  = REG_DATA_WIDTH;
    localparam int SW = $clog2(W);
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SLT = 4'd3,
                           OP_SLTU = 4'd4, OP_XOR = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                           OP_OR = 4'd8, OP_AND = 4'd9, OP_MUL = 4'd10, OP_MULHU = 4'd11;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     result_q, result_d, opnd_q, opnd_d;
    logic [2*W-1:0]   acc_q, acc_d, acc_n;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic             illegal_q, illegal_d, qneg_q, qneg_d, rneg_q, rneg_d;
    logic [3:0]       ctrl_q, ctrl_d;

    logic             is_op, is_imm, alt, zero7, is_m, base_ok, legal, dec_div, a_neg, b_neg, div_zero;
    logic [3:0]       dec, mdec;
    logic [SW-1:0]    shamt;
    logic [W-1:0]     base_res, sra_res, a_mag, b_mag, fin;
    logic [W:0]       mul_sum, div_diff;

    always_comb begin
        is_op    = opcode == 7'b0110011;
        is_imm   = opcode == 7'b0010011;
        alt      = funct7 == 7'b0100000;
        zero7    = funct7 == 7'b0000000;
        is_m     = is_op && funct7 == 7'b0000001;
        shamt    = rs2_data[SW-1:0];
        sra_res  = $signed(rs1_data) >>> shamt;
        base_ok  = is_imm || zero7;
        dec      = OP_AND;
        base_res = rs1_data & rs2_data;
        case (funct3)
            3'b000: begin
                dec      = (is_op && alt) ? OP_SUB : OP_ADD;
                base_ok  = is_imm || zero7 || alt;
                base_res = (is_op && alt) ? rs1_data - rs2_data : rs1_data + rs2_data;
            end
            3'b001: begin
                dec      = OP_SLL;
                base_ok  = zero7;
                base_res = rs1_data << shamt;
            end
            3'b010: begin
                dec      = OP_SLT;
                base_res = {{(W-1){1'b0}}, $signed(rs1_data) < $signed(rs2_data)};
            end
            3'b011: begin
                dec      = OP_SLTU;
                base_res = {{(W-1){1'b0}}, rs1_data < rs2_data};
            end
            3'b100: begin
                dec      = OP_XOR;
                base_res = rs1_data ^ rs2_data;
            end
            3'b101: begin
                dec      = alt ? OP_SRA : OP_SRL;
                base_ok  = zero7 || alt;
                base_res = alt ? sra_res : rs1_data >> shamt;
            end
            3'b110: begin
                dec      = OP_OR;
                base_res = rs1_data | rs2_data;
            end
            default: ;
        endcase
        // DIV/DIVU/REM/REMU encode as {1, funct3} so bit 1 separates remainder from quotient
        mdec     = funct3 == 3'b000 ? OP_MUL : funct3 == 3'b011 ? OP_MULHU : {1'b1, funct3};
        legal    = is_m ? (MULDIV_EN && funct3 != 3'b001 && funct3 != 3'b010) : ((is_op || is_imm) && base_ok);
        dec_div  = funct3[2];
        div_zero = dec_div && rs2_data == '0;
        a_neg    = dec_div && !funct3[0] && rs1_data[W-1];
        b_neg    = dec_div && !funct3[0] && rs2_data[W-1];
        a_mag    = a_neg ? -rs1_data : rs1_data;
        b_mag    = b_neg ? -rs2_data : rs2_data;
    end

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_diff = acc_q[2*W-1:W-1] - {1'b0, opnd_q};
        acc_n    = ctrl_q[3:2] != 2'b11 ? {mul_sum, acc_q[W-1:1]} :
                   div_diff[W] ? {acc_q[2*W-2:0], 1'b0} : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
        fin      = ctrl_q == OP_MUL ? acc_n[W-1:0] : ctrl_q == OP_MULHU ? acc_n[2*W-1:W] :
                   ctrl_q[1] ? (rneg_q ? -acc_n[2*W-1:W] : acc_n[2*W-1:W]) :
                   (qneg_q ? -acc_n[W-1:0] : acc_n[W-1:0]);
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        ctrl_d    = ctrl_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        cnt_d     = cnt_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d   = DONE;
                illegal_d = !legal;
                ctrl_d    = !legal ? OP_ADD : is_m ? mdec : dec;
                result_d  = !legal ? '0 : !is_m ? base_res : div_zero ? (funct3[1] ? rs1_data : '1) : '0;
                if (legal && is_m && !div_zero) begin
                    state_d = ITER;
                    cnt_d   = SW'(W - 1);
                    acc_d   = {{W{1'b0}}, dec_div ? a_mag : rs1_data};
                    opnd_d  = dec_div ? b_mag : rs2_data;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                end
            end
            ITER: begin
                acc_d = acc_n;
                cnt_d = cnt_q - SW'(cnt_q != '0);
                if (cnt_q == '0) begin
                    state_d  = DONE;
                    result_d = fin;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= IDLE;
            result_q  <= '0;
            illegal_q <= 1'b0;
            ctrl_q    <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            cnt_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
            ctrl_q    <= ctrl_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            cnt_q     <= cnt_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign result    = result_q;
    assign illegal   = illegal_q;
    assign alu_ctrl  = ctrl_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vectors with literal expectations, cross-checked against a
// plain-arithmetic model of the RV32IM semantics and latencies.
module tb_alu_sequencer;
    localparam logic [6:0] OPC = 7'h33, IMM = 7'h13, LD = 7'h03, ALT = 7'h20, MX = 7'h01, Z7 = 7'h00;

    logic        clk = 1'b0, nreset = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, illegal, busy;
    logic [6:0]  opcode = '0, funct7 = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1_data = '0, rs2_data = '0, result;
    logic [3:0]  alu_ctrl;

    int          n_checks = 0, n_fail = 0;
    logic [31:0] exp_res = '0;
    logic        exp_ill = 1'b0;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a, b, res;
        logic        ill;
        int          lat;
    } vec_t;

    alu_sequencer #(.REG_DATA_WIDTH(32), .MULDIV_EN(1'b1)) dut (
        .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .illegal(illegal), .alu_ctrl(alu_ctrl), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference semantics straight from the ISA definitions, using 64-bit arithmetic
    function automatic void model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill, output int lat);
        longint      sa, sb;
        logic [63:0] p;
        int          sh;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        p   = {32'h0, a} * {32'h0, b};
        sh  = int'(b[4:0]);
        r   = '0;
        ill = 1'b1;
        lat = 1;
        if (op == OPC && f7 == MX) begin
            ill = f3 == 3'd1 || f3 == 3'd2;
            lat = (ill || (f3[2] && b == 0)) ? 1 : 33;
            if (f3 == 3'd0) r = p[31:0];
            else if (f3 == 3'd3) r = p[63:32];
            else if (f3 == 3'd4) r = b == 0 ? 32'hFFFF_FFFF : 32'(sa / sb);
            else if (f3 == 3'd5) r = b == 0 ? 32'hFFFF_FFFF : a / b;
            else if (f3 == 3'd6) r = b == 0 ? a : 32'(sa % sb);
            else if (f3 == 3'd7) r = b == 0 ? a : a % b;
        end else if (op == OPC || op == IMM) begin
            ill = op == OPC && f7 != Z7;
            case (f3)
                3'd0: begin r = (op == OPC && f7 == ALT) ? a - b : a + b; ill = op == OPC && f7 != Z7 && f7 != ALT; end
                3'd1: begin r = a << sh; ill = f7 != Z7; end
                3'd2: r = sa < sb ? 32'd1 : 32'd0;
                3'd3: r = a < b ? 32'd1 : 32'd0;
                3'd4: r = a ^ b;
                3'd5: begin r = f7 == ALT ? 32'(sa >>> sh) : a >> sh; ill = f7 != Z7 && f7 != ALT; end
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end
        if (ill) r = '0;
    endfunction

    // Every cycle a result is presented it must match the model's expectation
    always @(negedge clk) begin
        if (nreset && out_valid) begin
            check("out_result", result, exp_res);
            check("out_illegal", illegal, exp_ill);
            check("out_in_ready", in_ready, 0);
        end
    end

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                                input logic ill, input int lat);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.a = a; v.b = b; v.res = res; v.ill = ill; v.lat = lat;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        opcode = v.op; funct3 = v.f3; funct7 = v.f7; rs1_data = v.a; rs2_data = v.b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        opcode = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
        rs1_data = $urandom; rs2_data = $urandom;
    endtask

    task automatic run_op(input vec_t v, input int hold);
        logic [31:0] mr;
        logic        mi;
        int          ml, lat;
        logic [3:0]  ctl;
        model(v.op, v.f3, v.f7, v.a, v.b, mr, mi, ml);
        check("model_result", mr, v.res);
        check("model_illegal", mi, v.ill);
        check("model_latency", ml, v.lat);
        exp_res = mr;
        exp_ill = mi;
        check("idle_in_ready", in_ready, 1);
        drive(v);
        lat = 1;
        while (!out_valid && lat < 60) begin
            check("busy_iter", busy, 1);
            @(negedge clk);
            lat++;
        end
        check("latency", lat, v.lat);
        check("result", result, v.res);
        check("illegal", illegal, v.ill);
        check("busy_done", busy, 1);
        ctl = alu_ctrl;
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0];
            opcode = OPC; funct3 = 3'd0; funct7 = Z7; rs1_data = 32'd1; rs2_data = 32'd1;
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_alu_ctrl", alu_ctrl, ctl);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", out_valid, 0);
        check("release_idle", in_ready, 1);
    endtask

    vec_t tbl[$];

    initial begin
        tbl.push_back(mk(OPC, 3'd0, Z7,  32'd5,         32'd7,         32'h0000_000C, 0, 1));
        tbl.push_back(mk(OPC, 3'd0, ALT, 32'd3,         32'd5,         32'hFFFF_FFFE, 0, 1));
        tbl.push_back(mk(OPC, 3'd5, ALT, 32'h8000_0000, 32'd4,         32'hF800_0000, 0, 1));
        tbl.push_back(mk(IMM, 3'd5, ALT, 32'h8000_0000, 32'd4,         32'hF800_0000, 0, 1));
        tbl.push_back(mk(OPC, 3'd5, Z7,  32'h8000_0000, 32'h21,        32'h4000_0000, 0, 1));
        tbl.push_back(mk(OPC, 3'd1, Z7,  32'd1,         32'h1F,        32'h8000_0000, 0, 1));
        tbl.push_back(mk(OPC, 3'd2, Z7,  32'hFFFF_FFFF, 32'd1,         32'd1,         0, 1));
        tbl.push_back(mk(OPC, 3'd3, Z7,  32'hFFFF_FFFF, 32'd1,         32'd0,         0, 1));
        tbl.push_back(mk(IMM, 3'd0, 7'h7F, 32'd10,      32'hFFFF_FFFF, 32'd9,         0, 1));
        tbl.push_back(mk(OPC, 3'd4, Z7,  32'hF0F0,      32'hFF00,      32'h0FF0,      0, 1));
        tbl.push_back(mk(OPC, 3'd6, Z7,  32'hF0F0,      32'hFF00,      32'hFFF0,      0, 1));
        tbl.push_back(mk(OPC, 3'd7, Z7,  32'hF0F0,      32'hFF00,      32'hF000,      0, 1));
        tbl.push_back(mk(OPC, 3'd0, MX,  32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 0, 33));
        tbl.push_back(mk(OPC, 3'd3, MX,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 0, 33));
        tbl.push_back(mk(OPC, 3'd5, MX,  32'd7,         32'd0,         32'hFFFF_FFFF, 0, 1));
        tbl.push_back(mk(OPC, 3'd7, MX,  32'd7,         32'd0,         32'h0000_0007, 0, 1));
        tbl.push_back(mk(OPC, 3'd4, MX,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 33));
        tbl.push_back(mk(OPC, 3'd6, MX,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0, 33));
        tbl.push_back(mk(OPC, 3'd4, MX,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0, 33));
        tbl.push_back(mk(OPC, 3'd6, MX,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0, 33));
        tbl.push_back(mk(OPC, 3'd4, MX,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 0, 33));
        tbl.push_back(mk(OPC, 3'd6, MX,  32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 0, 33));
        tbl.push_back(mk(OPC, 3'd5, MX,  32'd100,       32'd7,         32'd14,        0, 33));
        tbl.push_back(mk(OPC, 3'd7, MX,  32'd100,       32'd7,         32'd2,         0, 33));
        tbl.push_back(mk(LD,  3'd0, Z7,  32'd5,         32'd7,         32'd0,         1, 1));
        tbl.push_back(mk(OPC, 3'd1, MX,  32'd5,         32'd7,         32'd0,         1, 1));
        tbl.push_back(mk(OPC, 3'd0, 7'h02, 32'd5,       32'd7,         32'd0,         1, 1));
        tbl.push_back(mk(IMM, 3'd1, ALT, 32'd5,         32'd1,         32'd0,         1, 1));

        @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_result", result, 0);
        check("rst_illegal", illegal, 0);
        check("rst_alu_ctrl", alu_ctrl, 0);
        @(negedge clk);
        nreset = 1'b1;

        foreach (tbl[i]) run_op(tbl[i], 0);
        run_op(tbl[13], 5);

        drive(mk(OPC, 3'd5, MX, 32'd100, 32'd7, 32'd14, 0, 33));
        repeat (9) @(negedge clk);
        check("pre_abort_busy", busy, 1);
        nreset = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_result", result, 0);
        check("abort_alu_ctrl", alu_ctrl, 0);
        @(negedge clk);
        nreset = 1'b1;
        run_op(mk(OPC, 3'd0, Z7, 32'd1, 32'd1, 32'd2, 0, 1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The parameters SHALL be one per line:
  REG_DATA_WIDTH  32  operand/result width (XLEN), >= 8
  MULDIV_EN       1   1 = M-extension ops executed; 0 = M ops flagged illegal
REQ-002 The ports SHALL be one per line:
  clk        in   1                 single clock, rising edge
  nreset     in   1                 reset, asynchronous, active-low
  in_valid   in   1                 request valid
  in_ready   out  1                 request accepted when in_valid & in_ready
  opcode     in   7                 RISC-V opcode
  funct3     in   3                 RISC-V funct3
  funct7     in   7                 RISC-V funct7
  rs1_data   in   REG_DATA_WIDTH    operand A
  rs2_data   in   REG_DATA_WIDTH    operand B (sign-extended immediate for OP-IMM)
  out_valid  out  1                 result valid
  out_ready  in   1                 result consumed when out_valid & out_ready
  result     out  REG_DATA_WIDTH    operation result
  illegal    out  1                 qualifies result: unsupported encoding
  alu_ctrl   out  4                 registered decoded operation code of current op
  busy       out  1                 high in any state other than IDLE

Function
REQ-003 The decode SHALL accept opcode 0110011 (OP) and 0010011 (OP-IMM); any other opcode is illegal.
REQ-004 Base ops by funct3: 000 ADD (SUB if OP and funct7=0100000), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if funct7=0100000), 110 OR, 111 AND.
REQ-005 Shift amount SHALL be rs2_data[$clog2(REG_DATA_WIDTH)-1:0]; funct7 other than 0000000/0100000 on OP, or on OP-IMM shifts, is illegal.
REQ-006 OP with funct7=0000001 SHALL select M ops: 000 MUL, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU; 001 MULH and 010 MULHSU are illegal; all M ops illegal when MULDIV_EN=0.
REQ-007 State machine SHALL have states IDLE, ITER, DONE; in_ready=1 only in IDLE.
REQ-008 IDLE, accept of base, illegal, or zero-divisor op -> DONE next edge; out_valid rises the cycle after accept (latency 1).
REQ-009 IDLE, accept of M op with non-zero divisor (or any MUL/MULHU) -> ITER; iteration counter loads REG_DATA_WIDTH-1.
REQ-010 ITER SHALL perform one shift-add (multiply) or one restoring-subtract (divide) step per cycle on a 2*REG_DATA_WIDTH accumulator; -> DONE when counter reaches 0; out_valid rises exactly REG_DATA_WIDTH+1 cycles after accept.
REQ-011 MUL returns low half, MULHU high half of the unsigned product.
REQ-012 DIV/REM SHALL operate on magnitudes, negate quotient when operand signs differ, give remainder the sign of rs1_data.
REQ-013 Divide by zero: DIV/DIVU result all ones; REM/REMU result rs1_data; no ITER.
REQ-014 Signed overflow (most-negative / -1): DIV result most-negative, REM result 0.
REQ-015 DONE SHALL hold result, illegal, alu_ctrl stable while out_ready=0; on out_ready=1 -> IDLE next edge, out_valid falls.
REQ-016 No new request is accepted in the DONE cycle of handshake; back-to-back throughput is one op per 2 cycles minimum.
REQ-017 Illegal op SHALL return result 0 with illegal=1; illegal=0 for all legal ops.
REQ-018 Operands and decode SHALL be captured at accept; input changes afterwards SHALL not affect the in-flight op.

Reset
REQ-019 nreset low SHALL immediately force IDLE, out_valid=0, result=0, illegal=0, alu_ctrl=0, busy=0, counter=0; in_ready=1 while in IDLE.
REQ-020 Reset asserted in ITER or DONE SHALL abort the op with no result delivered; first accept is allowed on the first rising edge after nreset rises.

Verification (REG_DATA_WIDTH=32, MULDIV_EN=1)
REQ-021 ADD 5+7 (OP, funct7=0) -> result 0x0000000C, illegal=0, out_valid one cycle after accept; SUB 3-5 -> 0xFFFFFFFE; SRA 0x80000000 by 4 -> 0xF8000000.
REQ-022 MUL 0x00010000*0x00010000 -> 0x00000000; MULHU same operands -> 0x00000001; out_valid exactly 33 cycles after accept, busy high throughout.
REQ-023 DIVU 7/0 -> 0xFFFFFFFF, REMU 7/0 -> 0x00000007, each latency 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-024 DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF; opcode 0000011 -> result 0, illegal=1, latency 1.
REQ-025 Hold out_ready=0 for 5 cycles after out_valid -> result/alu_ctrl stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-026 Assert nreset at cycle 10 of a DIVU -> out_valid=0, busy=0 immediately; after release a new ADD 1+1 returns 0x00000002 with latency 1.
